// File: rtl/pw_feeder.sv
`default_nettype none
// pw_feeder: packs weight/activation byte streams little-endian into MAC_IN_NUM-byte words
// and sequences one layer as MAC_OUT_NUM weight words followed by pix_num activation words.
module pw_feeder #(
   parameter int MAC_IN_NUM   = 10,
   parameter int MAC_OUT_NUM  = 16,
   parameter int DATA_WIDTH   = 8,
   parameter int CNT_WIDTH    = 10,
   parameter int MAC_IN_WIDTH = MAC_IN_NUM*DATA_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [CNT_WIDTH-1:0]    pix_num,
   input  logic                    pw_stall,
   input  logic [DATA_WIDTH-1:0]   w_data,
   input  logic                    w_valid,
   output logic                    w_ready,
   input  logic [DATA_WIDTH-1:0]   a_data,
   input  logic                    a_valid,
   output logic                    a_ready,
   output logic [MAC_IN_WIDTH-1:0] fifo_rpram,
   output logic                    fifo_rpe,
   output logic [MAC_IN_WIDTH-1:0] fifo_rdata,
   output logic                    fifo_rde,
   output logic                    busy,
   output logic                    done
);

   localparam int BCW = (MAC_IN_NUM > 1) ? $clog2(MAC_IN_NUM) : 1;
   localparam logic [BCW-1:0]       LAST_BYTE  = BCW'(MAC_IN_NUM - 1);
   localparam logic [CNT_WIDTH-1:0] LAST_WWORD = CNT_WIDTH'(MAC_OUT_NUM - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD_W = 2'd1,
      RUN    = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic [CNT_WIDTH-1:0]    pix_lat;
   logic [CNT_WIDTH-1:0]    word_cnt;
   logic [BCW-1:0]          byte_cnt;
   logic [MAC_IN_WIDTH-1:0] pack;

   logic                    w_acc;
   logic                    a_acc;
   logic                    acc;
   logic                    word_end;
   logic                    last_w;
   logic                    last_a;
   logic [DATA_WIDTH-1:0]   byte_in;
   logic [MAC_IN_WIDTH-1:0] word_nxt;

   // Only one stream can be accepted at a time, so both share the pack register.
   assign w_acc    = w_valid & w_ready;
   assign a_acc    = a_valid & a_ready;
   assign acc      = w_acc | a_acc;
   assign byte_in  = w_acc ? w_data : a_data;
   assign word_end = acc && (byte_cnt == LAST_BYTE);
   assign last_w   = (word_cnt == LAST_WWORD);
   assign last_a   = (word_cnt == (pix_lat - CNT_WIDTH'(1)));
   assign word_nxt = {byte_in, pack[MAC_IN_WIDTH-1:DATA_WIDTH]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      w_ready   = 1'b0;
      a_ready   = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               state_nxt = LOAD_W;
            end
         end
         LOAD_W: begin
            w_ready = ~pw_stall;
            if (w_acc && word_end && last_w) begin
               state_nxt = (pix_lat == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            a_ready = ~pw_stall;
            if (a_acc && word_end && last_a) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Bytes shift in from the top, so after MAC_IN_NUM bytes the first one sits in [7:0].
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pix_lat    <= '0;
         word_cnt   <= '0;
         byte_cnt   <= '0;
         pack       <= '0;
         fifo_rpram <= '0;
         fifo_rdata <= '0;
         fifo_rpe   <= 1'b0;
         fifo_rde   <= 1'b0;
      end else begin
         fifo_rpe <= 1'b0;
         fifo_rde <= 1'b0;
         if ((state == IDLE) && start) begin
            pix_lat  <= pix_num;
            word_cnt <= '0;
            byte_cnt <= '0;
            pack     <= '0;
         end else if (acc) begin
            pack <= word_nxt;
            if (word_end) begin
               byte_cnt <= '0;
               if (w_acc) begin
                  fifo_rpram <= word_nxt;
                  fifo_rpe   <= 1'b1;
                  word_cnt   <= last_w ? '0 : (word_cnt + CNT_WIDTH'(1));
               end else begin
                  fifo_rdata <= word_nxt;
                  fifo_rde   <= 1'b1;
                  word_cnt   <= word_cnt + CNT_WIDTH'(1);
               end
            end else begin
               byte_cnt <= byte_cnt + BCW'(1);
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pw_feeder.sv
`default_nettype none
// tb_pw_feeder: randomized stimulus, byte-list reference model feeding a scoreboard,
// and an independent monitor that pops expectations on every strobe and done pulse.
module tb_pw_feeder;

   localparam int N  = 10;
   localparam int M  = 16;
   localparam int DW = 8;
   localparam int CW = 10;
   localparam int W  = N*DW;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [CW-1:0] pix_num;
   logic          pw_stall;
   logic [DW-1:0] w_data;
   logic          w_valid;
   logic          w_ready;
   logic [DW-1:0] a_data;
   logic          a_valid;
   logic          a_ready;
   logic [W-1:0]  fifo_rpram;
   logic          fifo_rpe;
   logic [W-1:0]  fifo_rdata;
   logic          fifo_rde;
   logic          busy;
   logic          done;

   pw_feeder #(
      .MAC_IN_NUM  (N),
      .MAC_OUT_NUM (M),
      .DATA_WIDTH  (DW),
      .CNT_WIDTH   (CW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .pix_num    (pix_num),
      .pw_stall   (pw_stall),
      .w_data     (w_data),
      .w_valid    (w_valid),
      .w_ready    (w_ready),
      .a_data     (a_data),
      .a_valid    (a_valid),
      .a_ready    (a_ready),
      .fifo_rpram (fifo_rpram),
      .fifo_rpe   (fifo_rpe),
      .fifo_rdata (fifo_rdata),
      .fifo_rde   (fifo_rde),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   // kind: 0 = weight word, 1 = activation word, 2 = done pulse
   typedef struct {
      int           kind;
      logic [W-1:0] data;
   } exp_t;

   exp_t         sb[$];
   int           total  = 0;
   int           passed = 0;
   logic [W-1:0] cur;
   int           k;
   logic [W-1:0] last_w_word;
   logic [W-1:0] last_a_word;
   bit           a_ready_seen;

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, want %h", nm, act, exp);
   endtask

   task automatic expire(input string nm);
      total++;
      $display("FAIL %s: timed out waiting for DUT", nm);
   endtask

   // Reference: every N accepted bytes of a stream form one word, byte k at bit 8k.
   task automatic model_byte(input bit isw, input logic [DW-1:0] b);
      cur = cur | (W'(b) << (8*k));
      k++;
      if (k == N) begin
         sb.push_back('{isw ? 0 : 1, cur});
         if (isw) last_w_word = cur;
         else     last_a_word = cur;
         cur = '0;
         k   = 0;
      end
   endtask

   task automatic pop_chk(input int kind, input logic [W-1:0] data, input string nm);
      exp_t e;
      if (sb.size() == 0) begin
         total++;
         $display("FAIL unexpected_%s: got event, want none", nm);
      end else begin
         e = sb.pop_front();
         chk({nm, "_kind"}, W'(e.kind), W'(kind));
         if (kind != 2) chk(nm, data, e.data);
      end
   endtask

   always @(negedge clk) begin
      if (fifo_rpe === 1'b1) pop_chk(0, fifo_rpram, "rpram");
      if (fifo_rde === 1'b1) pop_chk(1, fifo_rdata, "rdata");
      if (done === 1'b1) begin
         pop_chk(2, '0, "done");
         chk("busy_at_done", W'(busy), W'(1));
      end
      if (a_ready === 1'b1) a_ready_seen = 1'b1;
   end

   task automatic send(input bit isw, input logic [DW-1:0] d, input int gap, input int stall);
      logic got;
      int   n;
      if (gap > 0) begin
         w_valid = 1'b0;
         a_valid = 1'b0;
         repeat (gap) @(posedge clk);
         #1;
      end
      if (isw) begin w_data = d; w_valid = 1'b1; end
      else     begin a_data = d; a_valid = 1'b1; end
      if (stall > 0) begin
         pw_stall = 1'b1;
         repeat (stall) begin
            @(negedge clk);
            chk("ready_in_stall", W'(isw ? w_ready : a_ready), W'(0));
            @(posedge clk);
            #1;
         end
         pw_stall = 1'b0;
      end
      got = 1'b0;
      n   = 0;
      while (!got && n < 200) begin
         @(negedge clk);
         got = isw ? w_ready : a_ready;
         @(posedge clk);
         #1;
         n++;
      end
      if (!got) expire("byte_accept");
      else model_byte(isw, d);
   endtask

   task automatic wait_drain();
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) expire("drain");
      @(negedge clk);
      chk("busy_after_done", W'(busy), W'(0));
      chk("done_one_cycle", W'(done), W'(0));
      chk("rpram_hold", fifo_rpram, last_w_word);
      chk("rdata_hold", fifo_rdata, last_a_word);
      @(posedge clk);
      #1;
   endtask

   function automatic int rnd(input int mx);
      if (mx == 0) return 0;
      return ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, mx)) : 0;
   endfunction

   task automatic pulse_start(input int pix);
      start   = 1'b1;
      pix_num = CW'(pix);
      @(posedge clk);
      #1;
      start   = 1'b0;
      pix_num = CW'($urandom);
   endtask

   task automatic send_weights(input bit seq, input int gapmax, input int stallmax);
      for (int i = 0; i < N*M; i++)
         send(1'b1, seq ? DW'(i + 1) : DW'($urandom), rnd(gapmax), rnd(stallmax));
      w_valid = 1'b0;
   endtask

   task automatic run_layer(input int pix, input bit seq, input int gapmax, input int stallmax,
                            input bit stall_at3, input bit poke);
      cur = '0;
      k   = 0;
      pulse_start(pix);
      if (poke) begin
         a_data  = 8'hEE;
         a_valid = 1'b1;
         repeat (3) begin
            @(negedge clk);
            chk("a_ready_in_load_w", W'(a_ready), W'(0));
            @(posedge clk);
            #1;
         end
         a_valid = 1'b0;
      end
      send_weights(seq, gapmax, stallmax);
      if (pix == 0) begin
         sb.push_back('{2, '0});
      end else begin
         if (poke) begin
            start   = 1'b1;
            pix_num = CW'(7);
            w_data  = 8'h55;
            w_valid = 1'b1;
            @(negedge clk);
            chk("w_ready_in_run", W'(w_ready), W'(0));
            @(posedge clk);
            #1;
            start   = 1'b0;
            w_valid = 1'b0;
         end
         for (int i = 0; i < pix*N; i++)
            send(1'b0, DW'($urandom), rnd(gapmax),
                 (stall_at3 && i == 3) ? 5 : rnd(stallmax));
         a_valid = 1'b0;
         sb.push_back('{2, '0});
      end
      wait_drain();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst         = 1'b0;
      start       = 1'b0;
      pix_num     = '0;
      pw_stall    = 1'b0;
      w_data      = '0;
      w_valid     = 1'b0;
      a_data      = '0;
      a_valid     = 1'b0;
      cur         = '0;
      k           = 0;
      last_w_word = '0;
      last_a_word = '0;
      a_ready_seen = 1'b0;
      #1 rst = 1'b1;
      #1;
      chk("reset_ctrl", W'({busy, done, w_ready, a_ready, fifo_rpe, fifo_rde}), W'(0));
      chk("reset_rpram", fifo_rpram, '0);
      chk("reset_rdata", fifo_rdata, '0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;

      // Sequential weights 0x01..0xA0, two pixel words.
      run_layer(2, 1'b1, 0, 0, 1'b0, 1'b0);

      // Zero pixels: straight to DONE after weights, activation side never ready.
      a_ready_seen = 1'b0;
      run_layer(0, 1'b0, 0, 0, 1'b0, 1'b0);
      chk("a_ready_never_pix0", W'(a_ready_seen), W'(0));

      // Five-cycle stall after the third activation byte.
      run_layer(2, 1'b0, 0, 0, 1'b1, 1'b0);

      // Reset part way through the first activation word.
      cur = '0;
      k   = 0;
      pulse_start(3);
      send_weights(1'b0, 0, 0);
      for (int i = 0; i < 4; i++) send(1'b0, DW'($urandom), 0, 0);
      rst = 1'b1;
      #1;
      chk("midrst_ctrl", W'({busy, done, w_ready, a_ready, fifo_rpe, fifo_rde}), W'(0));
      chk("midrst_rpram", fifo_rpram, '0);
      chk("midrst_rdata", fifo_rdata, '0);
      sb.delete();
      cur         = '0;
      k           = 0;
      last_w_word = '0;
      last_a_word = '0;
      a_valid     = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("idle_after_rst", W'({busy, w_ready, a_ready}), W'(0));
      @(posedge clk);
      #1;
      run_layer(1, 1'b0, 0, 0, 1'b0, 1'b0);

      // Wrong-state traffic plus random gaps and stalls.
      run_layer(3, 1'b0, 2, 2, 1'b0, 1'b1);
      for (int t = 0; t < 3; t++)
         run_layer(int'($urandom_range(1, 4)), 1'b0, 3, 3, 1'b0, 1'b0);

      repeat (5) @(posedge clk);
      if (sb.size() != 0) expire("final_drain");
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
